spi_frame_slave: RTL and testbench
==================================

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 The block SHALL expose these parameters:
- BUFFER_SIZE, default 96: frame length in bits; a multiple of 8 and at least 40.
- MSGID, default 32'h74697277: required header value.
- CPOL, default 0: SCK idle level.
- CPHA, default 0: sampling phase.
- TIMEOUT, default 32'd5000000: watchdog limit in clk cycles.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous and active-high.
- SPI_SCK, in, 1: SPI clock, asynchronous to clk.
- SPI_SSEL, in, 1: chip select, active-low, asynchronous.
- SPI_MOSI, in, 1: serial data in, asynchronous.
- SPI_MISO, out, 1: serial data out.
- tx_data, in, BUFFER_SIZE: reply frame.
- rx_data, out, BUFFER_SIZE: last valid received frame.
- pkg_ok, out, 1: one-cycle strobe for a valid frame.
- frame_err, out, 1: one-cycle strobe for a rejected frame.
- err_count, out, 8: count of rejected frames.
- timeout, out, 1: watchdog expired.

REQ-003 There SHALL be exactly one clock, clk; all state SHALL be updated only on its rising edge, and rst SHALL be synchronous and active-high.

Function
REQ-004 SPI_SCK, SPI_SSEL and SPI_MOSI SHALL each pass through a 3-flop synchroniser; edges SHALL be detected on the last two stages.
- The supported ratio is clk frequency >= 8x SCK frequency.

REQ-005 The leading SCK edge SHALL be the rising edge when CPOL=0 and the falling edge when CPOL=1.
- CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge.
- CPHA=1: shift MISO on the leading edge, sample MOSI on the trailing edge.

REQ-006 The FSM SHALL have the states IDLE, ACTIVE and CHECK.
- IDLE->ACTIVE on a synchronised SSEL falling edge.
- ACTIVE->CHECK on an SSEL rising edge.
- CHECK->IDLE unconditionally after one cycle.

REQ-007 On IDLE->ACTIVE the block SHALL:
- latch tx_data into the tx shift register;
- clear the bit counter;
- drive SPI_MISO with tx_data[BUFFER_SIZE-1].

REQ-008 In ACTIVE:
- each sample edge SHALL shift MOSI into the LSB of the rx shift register (MSB-first);
- each shift edge SHALL advance MISO to the next lower bit.

REQ-009 SCK edges SHALL be ignored in IDLE and in CHECK.

REQ-010 The bit counter SHALL saturate at BUFFER_SIZE+1, so that overlength frames are detectable.

REQ-011 In CHECK, a frame SHALL be valid iff the bit count equals BUFFER_SIZE and the rx shift register bits [BUFFER_SIZE-1:BUFFER_SIZE-32] equal MSGID.

REQ-012 For a valid frame, on the cycle after CHECK the block SHALL load rx_data from the rx shift register and hold pkg_ok high for exactly 1 cycle.

REQ-013 For an invalid frame (short, long or bad header), the block SHALL:
- leave rx_data unchanged;
- hold frame_err high for exactly 1 cycle, with timing identical to pkg_ok;
- increment err_count, saturating at 255.

REQ-014 pkg_ok and frame_err SHALL never be high in the same cycle.

REQ-015 SPI_MISO SHALL be 0 whenever the FSM is not in ACTIVE.

REQ-016 An SSEL glitch shorter than 3 clk cycles MAY be missed; a missed glitch SHALL NOT corrupt the FSM.

Reset
REQ-017 While rst is high, the block SHALL drive:
- rx_data=0, pkg_ok=0, frame_err=0, err_count=0, timeout=0, SPI_MISO=0;
- FSM in IDLE, bit counter 0, watchdog counter 0;
- synchroniser flops to their idle levels (SSEL=1, SCK=CPOL).

REQ-018 Reset asserted mid-frame SHALL discard the frame.
- After reset, entering ACTIVE SHALL require SSEL to be seen high and then a fresh SSEL falling edge.

Configuration
REQ-019 With SPI_FRAME_TIMEOUT_EN defined, a watchdog counter SHALL:
- count clk cycles since the last pkg_ok;
- on reaching TIMEOUT, set timeout=1, clear rx_data to 0 and hold the count;
- clear timeout and the count on the next pkg_ok;
- give pkg_ok priority if pkg_ok and expiry coincide (count resets, timeout stays 0).

REQ-020 Without SPI_FRAME_TIMEOUT_EN, the watchdog logic SHALL be absent, timeout SHALL be tied to 0, and rx_data SHALL hold indefinitely.

Verification
REQ-021 The bench SHALL cover these directed scenarios (BUFFER_SIZE=96, clk=10x SCK):
- Mode 0, MOSI=96'h74697277_A1177AA1_177A8001 -> pkg_ok pulses once; rx_data equals that value; MISO stream equals tx_data=96'h64617461_000088B8_AA000000.
- Mode 3 (CPOL=1, CPHA=1), same frame -> identical rx_data and MISO results.
- Header 32'h74697278 -> frame_err pulses; rx_data unchanged; err_count=1.
- 88-bit frame, then 104-bit frame -> two frame_err pulses; err_count=2.
- rst asserted at bit 40 with SSEL held low -> no pkg_ok; the next clean frame is accepted.
- SPI_FRAME_TIMEOUT_EN defined, TIMEOUT=1000: valid frame then 1000 idle cycles -> timeout=1 and rx_data=0; the next valid frame clears timeout.

Source files
------------

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: SPI slave exchanging fixed BUFFER_SIZE-bit frames (clk/rst/SPI_* in, SPI_MISO/rx_data/pkg_ok/frame_err/err_count/timeout out); SPI_FRAME_TIMEOUT_EN adds an rx_data watchdog
module spi_frame_slave #(
  parameter int          BUFFER_SIZE = 96,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter logic [31:0] TIMEOUT     = 32'd5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SPI_SCK,
  input  logic                   SPI_SSEL,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   pkg_ok,
  output logic                   frame_err,
  output logic [7:0]             err_count,
  output logic                   timeout
);
  localparam int CW = $clog2(BUFFER_SIZE + 2);
  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;
  state_t state, state_nx;
  logic [2:0] sck_s, ssel_s, mosi_s, fill;
  logic armed;
  logic [BUFFER_SIZE-1:0] rx_sr, tx_sr;
  logic [CW-1:0] cnt;
  logic sck_rise, sck_fall, lead, trail, sample, shift, ssel_fall, ssel_rise, start, valid, ok_set, err_set;
  assign sck_rise  = sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] & sck_s[2];
  assign ssel_rise = ssel_s[1] & ~ssel_s[2];
  assign ssel_fall = ~ssel_s[1] & ssel_s[2];
  assign lead      = CPOL ? sck_fall : sck_rise;
  assign trail     = CPOL ? sck_rise : sck_fall;
  assign sample    = (state == ACTIVE) & (CPHA ? trail : lead);
  assign shift     = (state == ACTIVE) & (CPHA ? lead & (cnt != '0) : trail);
  assign start     = (state == IDLE) & ssel_fall & armed;
  assign valid     = (cnt == CW'(BUFFER_SIZE)) && (rx_sr[BUFFER_SIZE-1 -: 32] == MSGID);
  assign ok_set    = (state == CHECK) & valid;
  assign err_set   = (state == CHECK) & ~valid;
  always_comb begin
    state_nx = IDLE;
    SPI_MISO = 1'b0;
    state_nx = (state == IDLE) ? (start ? ACTIVE : IDLE) :
               (state == ACTIVE) ? (ssel_rise ? CHECK : ACTIVE) : IDLE;
    SPI_MISO = (state == ACTIVE) & tx_sr[BUFFER_SIZE-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s     <= {3{CPOL}};
      ssel_s    <= 3'b111;
      mosi_s    <= 3'b000;
      fill      <= 3'b000;
      armed     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      pkg_ok    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      sck_s     <= {sck_s[1:0], SPI_SCK};
      ssel_s    <= {ssel_s[1:0], SPI_SSEL};
      mosi_s    <= {mosi_s[1:0], SPI_MOSI};
      fill      <= {fill[1:0], 1'b1};
      armed     <= armed | (fill[2] & ssel_s[2]);
      state     <= state_nx;
      pkg_ok    <= ok_set;
      frame_err <= err_set;
      if (start) begin
        tx_sr <= tx_data;
        cnt   <= '0;
      end else if (shift)
        tx_sr <= {tx_sr[BUFFER_SIZE-2:0], 1'b0};
      if (sample) begin
        rx_sr <= {rx_sr[BUFFER_SIZE-2:0], mosi_s[2]};
        cnt   <= (cnt == CW'(BUFFER_SIZE + 1)) ? cnt : cnt + 1'b1;
      end
      if (err_set && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`ifdef SPI_FRAME_TIMEOUT_EN
  logic [31:0] wd;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= 32'd0;
      timeout <= 1'b0;
      rx_data <= '0;
    end else if (ok_set) begin
      wd      <= 32'd0;
      timeout <= 1'b0;
      rx_data <= rx_sr;
    end else if (wd == TIMEOUT) begin
      timeout <= 1'b1;
      rx_data <= '0;
    end else
      wd <= wd + 32'd1;
  end
`else
  assign timeout = 1'b0;
  always_ff @(posedge clk) begin
    if (rst)
      rx_data <= '0;
    else if (ok_set)
      rx_data <= rx_sr;
  end
`endif
endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: directed bench for spi_frame_slave in modes 0 and 3 plus a short-watchdog instance
module tb_spi_frame_slave;
  localparam logic [95:0] A   = 96'h74697277_A1177AA1_177A8001;
  localparam logic [95:0] BAD = 96'h74697278_A1177AA1_177A8001;
  localparam logic [95:0] B   = 96'h74697277_00000000_DEADBEEF;
  localparam logic [95:0] C   = 96'h74697277_12345678_9ABCDEF0;
  localparam logic [95:0] TX  = 96'h64617461_000088B8_AA000000;
  logic clk = 1'b0, rst, sck0, sck3, ssel, mosi;
  logic [95:0] tx, rx0, rx3, rxt, m0, m3;
  logic miso0, miso3, misot, ok0, ok3, okt, fe0, fe3, fet, to0, to3, tot;
  logic [7:0] ec0, ec3, ect;
  int n_ok0 = 0, n_ok3 = 0, n_okt = 0, n_fe0 = 0, n_fe3 = 0, n_both = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  spi_frame_slave #(.CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst(rst), .SPI_SCK(sck0), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(miso0),
    .tx_data(tx), .rx_data(rx0), .pkg_ok(ok0), .frame_err(fe0), .err_count(ec0), .timeout(to0));
  spi_frame_slave #(.CPOL(1'b1), .CPHA(1'b1)) u3 (
    .clk(clk), .rst(rst), .SPI_SCK(sck3), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(miso3),
    .tx_data(tx), .rx_data(rx3), .pkg_ok(ok3), .frame_err(fe3), .err_count(ec3), .timeout(to3));
  spi_frame_slave #(.CPOL(1'b0), .CPHA(1'b0), .TIMEOUT(32'd1000)) ut (
    .clk(clk), .rst(rst), .SPI_SCK(sck0), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(misot),
    .tx_data(tx), .rx_data(rxt), .pkg_ok(okt), .frame_err(fet), .err_count(ect), .timeout(tot));
  always @(negedge clk) begin
    n_ok0 += int'(ok0);
    n_ok3 += int'(ok3);
    n_okt += int'(okt);
    n_fe0 += int'(fe0);
    n_fe3 += int'(fe3);
    n_both += int'((ok0 & fe0) | (ok3 & fe3) | (okt & fet));
  end
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Mode 0 and mode 3 both sample on the SCK rising edge here, so one bit loop drives both.
  task automatic frame(input logic [127:0] d, input int n, input int rst_at);
    ssel = 1'b0;
    #100;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      sck3 = 1'b0;
      mosi = d[n-1-i];
      #50;
      m0 = {m0[94:0], miso0};
      m3 = {m3[94:0], miso3};
      sck0 = 1'b1;
      sck3 = 1'b1;
      #50;
      sck0 = 1'b0;
    end
    #100;
    ssel = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; ssel = 1'b1; sck0 = 1'b0; sck3 = 1'b1; mosi = 1'b0; tx = TX; m0 = '0; m3 = '0;
    repeat (5) @(negedge clk);
    check("rst_rx", 128'(rx0), 128'(0));
    check("rst_ok_err", {ok0, fe0, ok3, fe3}, 4'b0);
    check("rst_errcnt", 128'(ec0), 128'(0));
    check("rst_timeout", {to0, to3, tot}, 3'b0);
    check("rst_miso", {miso0, miso3}, 2'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    frame(128'(A), 96, -1);
    check("m0_ok", 128'(n_ok0), 128'(1));
    check("m3_ok", 128'(n_ok3), 128'(1));
    check("m0_rx", 128'(rx0), 128'(A));
    check("m3_rx", 128'(rx3), 128'(A));
    check("m0_miso", 128'(m0), 128'(TX));
    check("m3_miso", 128'(m3), 128'(TX));
    check("idle_miso", {miso0, miso3}, 2'b0);
    check("m0_no_err", 128'(n_fe0), 128'(0));
    frame(128'(BAD), 96, -1);
    check("hdr_fe0", 128'(n_fe0), 128'(1));
    check("hdr_fe3", 128'(n_fe3), 128'(1));
    check("hdr_no_ok", 128'(n_ok0), 128'(1));
    check("hdr_rx_hold", 128'(rx0), 128'(A));
    check("hdr_ec0", 128'(ec0), 128'(1));
    check("hdr_ec3", 128'(ec3), 128'(1));
    frame(128'(A), 96, 40);
    check("rst_mid_no_ok", 128'(n_ok0), 128'(1));
    check("rst_mid_no_err", 128'(n_fe0), 128'(1));
    check("rst_mid_ec", 128'(ec0), 128'(0));
    check("rst_mid_rx", 128'(rx0), 128'(0));
    frame(128'(B), 96, -1);
    check("clean_ok0", 128'(n_ok0), 128'(2));
    check("clean_ok3", 128'(n_ok3), 128'(2));
    check("clean_rx0", 128'(rx0), 128'(B));
    check("clean_rx3", 128'(rx3), 128'(B));
    frame(128'(A >> 8), 88, -1);
    frame({24'h0, A, 8'h55}, 104, -1);
    check("len_fe0", 128'(n_fe0), 128'(3));
    check("len_fe3", 128'(n_fe3), 128'(3));
    check("len_ec0", 128'(ec0), 128'(2));
    check("len_ec3", 128'(ec3), 128'(2));
    check("len_rx_hold", 128'(rx0), 128'(B));
    check("len_no_ok", 128'(n_ok0), 128'(2));
    frame(128'(C), 96, -1);
    check("wd_ok", 128'(n_okt), 128'(3));
    check("wd_rx", 128'(rxt), 128'(C));
    check("wd_fresh", 128'(tot), 128'(0));
    repeat (950) @(negedge clk);
    check("wd_early", 128'(tot), 128'(0));
    repeat (60) @(negedge clk);
`ifdef SPI_FRAME_TIMEOUT_EN
    check("wd_expired", 128'(tot), 128'(1));
    check("wd_rx_clear", 128'(rxt), 128'(0));
`else
    check("wd_absent", 128'(tot), 128'(0));
    check("wd_rx_hold", 128'(rxt), 128'(C));
`endif
    check("wd_long_default", {to0, to3}, 2'b0);
    frame(128'(A), 96, -1);
    check("wd_cleared", 128'(tot), 128'(0));
    check("wd_rx_new", 128'(rxt), 128'(A));
    check("ok_err_exclusive", 128'(n_both), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
